perceptron_frame_tx: RTL and testbench



---
 rtl/perceptron_frame_tx.sv | 138 +++++++++++++
 tb/tb_perceptron_frame_tx.sv | 414 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/perceptron_frame_tx.sv
// Byte-serial frame transmitter for perceptron results:
// SYNC, EPOCH, LEN, W[0..N_W-1], ACT, CHK over a valid/ready handshake.
module perceptron_frame_tx #(
    parameter int unsigned N_W       = 2,
    parameter logic [7:0]  SYNC_BYTE = 8'hA5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [8*N_W-1:0] w_flat,
    input  logic [7:0]       act_in,
    input  logic [7:0]       epoch_in,
    output logic [7:0]       tx_data,
    output logic             tx_valid,
    input  logic             tx_ready,
    output logic             busy,
    output logic             done
);

    typedef enum logic [2:0] {
        StIdle, StSync, StEpoch, StLen, StPayload, StAct, StChk
    } state_e;

    state_e             state_q, state_d;
    logic [3:0]         idx_q, idx_d;
    logic [7:0]         chk_q, chk_d;
    logic [8*N_W-1:0]   w_q, w_d;
    logic [7:0]         act_q, act_d;
    logic [7:0]         epoch_q, epoch_d;
    logic               done_q, done_d;
    logic [7:0]         payload_byte;
    logic               xfer;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            idx_q   <= '0;
            chk_q   <= '0;
            w_q     <= '0;
            act_q   <= '0;
            epoch_q <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            chk_q   <= chk_d;
            w_q     <= w_d;
            act_q   <= act_d;
            epoch_q <= epoch_d;
            done_q  <= done_d;
        end
    end

    // Weight selected by the payload index, from the snapshot only.
    always_comb begin
        payload_byte = 8'h00;
        for (int i = 0; i < int'(N_W); i++) begin
            if (idx_q == 4'(i)) begin
                payload_byte = w_q[8*i +: 8];
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        chk_d    = chk_q;
        w_d      = w_q;
        act_d    = act_q;
        epoch_d  = epoch_q;
        done_d   = 1'b0;
        tx_data  = 8'h00;
        tx_valid = (state_q != StIdle);
        busy     = (state_q != StIdle);
        xfer     = tx_valid && tx_ready;

        case (state_q)
            StIdle: begin
                if (start) begin
                    w_d     = w_flat;
                    act_d   = act_in;
                    epoch_d = epoch_in;
                    chk_d   = 8'h00;
                    idx_d   = 4'd0;
                    state_d = StSync;
                end
            end
            StSync: begin
                tx_data = SYNC_BYTE;
                if (xfer) state_d = StEpoch;
            end
            StEpoch: begin
                tx_data = epoch_q;
                if (xfer) begin
                    chk_d   = chk_q ^ epoch_q;
                    state_d = StLen;
                end
            end
            StLen: begin
                tx_data = 8'(N_W);
                if (xfer) begin
                    chk_d   = chk_q ^ 8'(N_W);
                    idx_d   = 4'd0;
                    state_d = StPayload;
                end
            end
            StPayload: begin
                tx_data = payload_byte;
                if (xfer) begin
                    chk_d = chk_q ^ payload_byte;
                    if (idx_q == 4'(N_W - 1)) begin
                        state_d = StAct;
                    end else begin
                        idx_d = idx_q + 4'd1;
                    end
                end
            end
            StAct: begin
                tx_data = act_q;
                if (xfer) begin
                    chk_d   = chk_q ^ act_q;
                    state_d = StChk;
                end
            end
            StChk: begin
                tx_data = chk_q;
                if (xfer) begin
                    done_d  = 1'b1;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    assign done = done_q;

endmodule

// File: tb/tb_perceptron_frame_tx.sv
// Self-checking bench for perceptron_frame_tx: a frame model built from the
// frame-format rules is compared against the bytes captured on the handshake.
module tb_perceptron_frame_tx;

    localparam int N_W = 2;
    typedef logic [7:0] byte_q_t[$];

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             start = 1'b0;
    logic [8*N_W-1:0] w_flat = '0;
    logic [7:0]       act_in = '0;
    logic [7:0]       epoch_in = '0;
    logic [7:0]       tx_data;
    logic             tx_valid;
    logic             tx_ready;
    logic             busy;
    logic             done;

    int n_cmp = 0;
    int n_err = 0;

    int      cyc = 0;
    int      ready_mode = 0;
    byte_q_t got;
    int      done_cnt = 0;
    int      done_cyc = -1;
    int      rise_cyc = -1;
    int      stall_err = 0;
    int      busy_err = 0;

    perceptron_frame_tx #(.N_W(N_W), .SYNC_BYTE(8'hA5)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .w_flat   (w_flat),
        .act_in   (act_in),
        .epoch_in (epoch_in),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready),
        .busy     (busy),
        .done     (done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: samples on the falling edge, records transfers and protocol errors.
    logic       prev_stall = 1'b0;
    logic       prev_valid = 1'b0;
    logic [7:0] prev_data = 8'h00;
    always @(negedge clk) begin
        if (tx_valid && !prev_valid) rise_cyc = cyc;
        if (prev_stall && (tx_valid !== 1'b1 || tx_data !== prev_data)) stall_err++;
        if (busy !== tx_valid) busy_err++;
        if (tx_valid === 1'b1 && tx_ready === 1'b1) got.push_back(tx_data);
        if (done === 1'b1) begin
            done_cnt++;
            done_cyc = cyc;
        end
        prev_stall = !rst && tx_valid && !tx_ready;
        prev_valid = tx_valid;
        prev_data  = tx_data;
    end

    // Sink ready pattern: 0 = always ready, 1 = 1,0,0 repeating, 2 = random.
    initial begin
        int rphase = 0;
        tx_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                0: tx_ready = 1'b1;
                1: begin
                    tx_ready = (rphase == 0);
                    rphase = (rphase + 1) % 3;
                end
                default: tx_ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    function automatic byte_q_t model_frame(input logic [8*N_W-1:0] w, input logic [7:0] a,
                                            input logic [7:0] e);
        byte_q_t q;
        byte_q_t body;
        logic [7:0] chk;
        chk = 8'h00;
        body.push_back(e);
        body.push_back(8'(N_W));
        for (int i = 0; i < N_W; i++) body.push_back(w[8*i +: 8]);
        body.push_back(a);
        q.push_back(8'hA5);
        foreach (body[i]) begin
            q.push_back(body[i]);
            chk = chk ^ body[i];
        end
        q.push_back(chk);
        return q;
    endfunction

    // Raises start for one edge; returns the cycle count right after the accepting edge.
    task automatic pulse_start(output int k);
        @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        k = cyc;
    endtask

    task automatic wait_done(input int target, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(posedge clk);
            #1;
            if (done_cnt >= target) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        #3 rst = 1'b1;
        #4;
        n_cmp++;
        if (tx_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || tx_data !== 8'h00) begin
            n_err++;
            $display("FAIL reset_outputs: got valid=%b busy=%b done=%b data=%h, want 0 0 0 00",
                     tx_valid, busy, done, tx_data);
        end
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        repeat (2) @(posedge clk);
    endtask

    task automatic test_basic();
        byte_q_t exp, obs;
        int base, dbase, sbase, k;
        bit ok;
        ready_mode = 0;
        @(posedge clk);
        #1;
        w_flat = {8'h09, 8'h04}; act_in = 8'h01; epoch_in = 8'h03;
        base = got.size(); dbase = done_cnt; sbase = busy_err;
        exp = model_frame(w_flat, act_in, epoch_in);
        pulse_start(k);
        wait_done(dbase + 1, 100, ok);
        repeat (3) @(posedge clk);
        for (int i = base; i < got.size(); i++) obs.push_back(got[i]);
        n_cmp++;
        if (!ok) begin
            n_err++;
            $display("FAIL basic_done_timeout: got no done, want done within 100 cycles");
        end
        n_cmp++;
        if (obs.size() != exp.size()) begin
            n_err++;
            $display("FAIL basic_len: got %0d bytes, want %0d", obs.size(), exp.size());
        end
        for (int i = 0; i < exp.size() && i < obs.size(); i++) begin
            n_cmp++;
            if (obs[i] !== exp[i]) begin
                n_err++;
                $display("FAIL basic_byte%0d: got %h, want %h", i, obs[i], exp[i]);
            end
        end
        n_cmp++;
        if (exp[6] !== 8'h0D || obs.size() < 7 || obs[6] !== 8'h0D) begin
            n_err++;
            $display("FAIL basic_chk: got %h, want 0d", (obs.size() > 6) ? obs[6] : 8'hxx);
        end
        n_cmp++;
        if (rise_cyc != k) begin
            n_err++;
            $display("FAIL sync_latency: got valid rise at cycle %0d, want %0d", rise_cyc, k);
        end
        n_cmp++;
        if (done_cyc != k + N_W + 5) begin
            n_err++;
            $display("FAIL done_latency: got done at %0d, want %0d", done_cyc, k + N_W + 5);
        end
        n_cmp++;
        if (done_cnt - dbase != 1 || busy_err != sbase) begin
            n_err++;
            $display("FAIL basic_done_busy: got %0d dones / %0d busy errors, want 1 / 0",
                     done_cnt - dbase, busy_err - sbase);
        end
    endtask

    task automatic test_stall();
        byte_q_t exp, obs;
        int base, dbase, sbase, k;
        bit ok;
        ready_mode = 1;
        base = got.size(); dbase = done_cnt; sbase = stall_err;
        exp = model_frame({8'h09, 8'h04}, 8'h01, 8'h03);
        w_flat = {8'h09, 8'h04}; act_in = 8'h01; epoch_in = 8'h03;
        pulse_start(k);
        wait_done(dbase + 1, 200, ok);
        repeat (3) @(posedge clk);
        ready_mode = 0;
        for (int i = base; i < got.size(); i++) obs.push_back(got[i]);
        n_cmp++;
        if (!ok || obs != exp) begin
            n_err++;
            $display("FAIL stall_frame: got %0d bytes (done=%0b), want %0d matching bytes",
                     obs.size(), ok, exp.size());
        end
        n_cmp++;
        if (stall_err != sbase) begin
            n_err++;
            $display("FAIL stall_hold: got %0d unstable stalls, want 0", stall_err - sbase);
        end
    endtask

    task automatic test_snapshot();
        byte_q_t exp1, exp2, obs;
        int base, dbase, k;
        bit ok;
        ready_mode = 2;
        base = got.size(); dbase = done_cnt;
        w_flat = {8'h09, 8'h04}; act_in = 8'h01; epoch_in = 8'h03;
        exp1 = model_frame(w_flat, act_in, epoch_in);
        exp2 = model_frame({8'hFF, 8'h80}, 8'h00, 8'h03);
        pulse_start(k);
        @(posedge clk);
        #1 w_flat = {8'hFF, 8'h80}; act_in = 8'h00;
        wait_done(dbase + 1, 200, ok);
        pulse_start(k);
        wait_done(dbase + 2, 200, ok);
        repeat (2) @(posedge clk);
        for (int i = base; i < got.size(); i++) obs.push_back(got[i]);
        n_cmp++;
        if (!ok || obs.size() != 14) begin
            n_err++;
            $display("FAIL snap_len: got %0d bytes, want 14", obs.size());
        end else begin
            for (int i = 0; i < 7; i++) begin
                n_cmp++;
                if (obs[i] !== exp1[i] || obs[i+7] !== exp2[i]) begin
                    n_err++;
                    $display("FAIL snap_byte%0d: got %h/%h, want %h/%h",
                             i, obs[i], obs[i+7], exp1[i], exp2[i]);
                end
            end
            n_cmp++;
            if (obs[13] !== 8'h7E) begin
                n_err++;
                $display("FAIL snap_chk2: got %h, want 7e", obs[13]);
            end
        end
    endtask

    task automatic test_start_busy();
        byte_q_t exp, obs;
        int base, dbase, k, k2;
        bit ok;
        ready_mode = 0;
        base = got.size(); dbase = done_cnt;
        w_flat = 16'($urandom); act_in = 8'($urandom); epoch_in = 8'($urandom);
        exp = model_frame(w_flat, act_in, epoch_in);
        pulse_start(k);
        pulse_start(k2);
        wait_done(dbase + 1, 100, ok);
        repeat (15) @(posedge clk);
        for (int i = base; i < got.size(); i++) obs.push_back(got[i]);
        n_cmp++;
        if (!ok || obs != exp || done_cnt - dbase != 1) begin
            n_err++;
            $display("FAIL start_busy: got %0d bytes / %0d dones, want 7 matching / 1",
                     obs.size(), done_cnt - dbase);
        end
    endtask

    task automatic test_reset_mid();
        byte_q_t exp, obs;
        int base, dbase, k;
        bit ok;
        ready_mode = 0;
        base = got.size(); dbase = done_cnt;
        w_flat = 16'h1234; act_in = 8'h56; epoch_in = 8'h78;
        pulse_start(k);
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(posedge clk);
            #1;
            if (got.size() - base >= 4) begin
                ok = 1'b1;
                break;
            end
        end
        #1 rst = 1'b1;
        #1;
        n_cmp++;
        if (!ok || tx_valid !== 1'b0 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL reset_mid: got valid=%b busy=%b (reached payload=%0b), want 0 0 1",
                     tx_valid, busy, ok);
        end
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        repeat (3) @(posedge clk);
        n_cmp++;
        if (done_cnt != dbase) begin
            n_err++;
            $display("FAIL reset_nodone: got %0d dones, want 0", done_cnt - dbase);
        end
        base = got.size(); dbase = done_cnt;
        w_flat = 16'($urandom); act_in = 8'($urandom); epoch_in = 8'($urandom);
        exp = model_frame(w_flat, act_in, epoch_in);
        pulse_start(k);
        wait_done(dbase + 1, 100, ok);
        repeat (2) @(posedge clk);
        for (int i = base; i < got.size(); i++) obs.push_back(got[i]);
        n_cmp++;
        if (!ok || obs != exp) begin
            n_err++;
            $display("FAIL reset_restart: got %0d bytes first=%h, want %0d bytes first=a5",
                     obs.size(), (obs.size() > 0) ? obs[0] : 8'hxx, exp.size());
        end
    endtask

    task automatic test_back_to_back();
        byte_q_t exp, obs;
        int base, dbase, k;
        bit ok;
        ready_mode = 0;
        base = got.size(); dbase = done_cnt;
        w_flat = 16'hA1B2; act_in = 8'hC3; epoch_in = 8'hD4;
        exp = model_frame(w_flat, act_in, epoch_in);
        pulse_start(k);
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(posedge clk);
            #1;
            if (done === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
        w_flat = 16'($urandom); act_in = 8'($urandom); epoch_in = 8'($urandom);
        begin
            byte_q_t e2;
            e2 = model_frame(w_flat, act_in, epoch_in);
            foreach (e2[i]) exp.push_back(e2[i]);
        end
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        n_cmp++;
        if (!ok || tx_valid !== 1'b1 || tx_data !== 8'hA5) begin
            n_err++;
            $display("FAIL b2b_sync: got valid=%b data=%h, want 1 a5", tx_valid, tx_data);
        end
        wait_done(dbase + 2, 100, ok);
        repeat (3) @(posedge clk);
        for (int i = base; i < got.size(); i++) obs.push_back(got[i]);
        n_cmp++;
        if (!ok || obs != exp || done_cnt - dbase != 2) begin
            n_err++;
            $display("FAIL b2b_frames: got %0d bytes / %0d dones, want %0d bytes / 2",
                     obs.size(), done_cnt - dbase, exp.size());
        end
    endtask

    task automatic test_random();
        byte_q_t exp, obs;
        int base, dbase, k;
        bit ok;
        ready_mode = 2;
        for (int f = 0; f < 6; f++) begin
            obs.delete();
            base = got.size(); dbase = done_cnt;
            w_flat = 16'($urandom); act_in = 8'($urandom); epoch_in = 8'($urandom);
            exp = model_frame(w_flat, act_in, epoch_in);
            pulse_start(k);
            w_flat = 16'($urandom); act_in = 8'($urandom); epoch_in = 8'($urandom);
            wait_done(dbase + 1, 300, ok);
            @(posedge clk);
            for (int i = base; i < got.size(); i++) obs.push_back(got[i]);
            n_cmp++;
            if (!ok || obs != exp) begin
                n_err++;
                $display("FAIL random_frame%0d: got %0d bytes (done=%0b), want %0d matching",
                         f, obs.size(), ok, exp.size());
            end
        end
        ready_mode = 0;
        n_cmp++;
        if (stall_err != 0 || busy_err != 0) begin
            n_err++;
            $display("FAIL protocol: got %0d stall / %0d busy errors, want 0 / 0",
                     stall_err, busy_err);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_stall();
        test_snapshot();
        test_start_busy();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
